// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: memory-wait stall, branch flush, load-use bubble.
// Optional stall-cycle counter enabled by defining PIPE_HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl #(
    parameter int REG_AW       = 4,
    parameter int WAIT_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_src1,
    input  logic [REG_AW-1:0] id_src2,
    input  logic              id_two_src,
    input  logic [REG_AW-1:0] ex_dest,
    input  logic              ex_mem_read,
    input  logic              branch_taken,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              pc_freeze,
    output logic              ifid_freeze,
    output logic              ifid_flush,
    output logic              idex_freeze,
    output logic              idex_flush,
    output logic              exmem_freeze,
    output logic              mem_abort,
    output logic              timeout_err
`ifdef PIPE_HAZARD_PERF_CNT_EN
    ,
    output logic [15:0]       stall_cycles
`endif
);

    typedef enum logic {
        RUN,
        MEM_WAIT
    } state_t;

    localparam logic [15:0] TMO = 16'(WAIT_TIMEOUT);

    state_t      state_q, state_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        timeout_err_q, timeout_err_d;
    logic        load_use;
    logic        src1_hit;
    logic        src2_hit;

    // Load-use: EX load writes a register the ID instruction reads (x0 excluded).
    always_comb begin
        src1_hit = (ex_dest == id_src1);
        src2_hit = id_two_src && (ex_dest == id_src2);
        load_use = ex_mem_read && (ex_dest != '0) && (src1_hit || src2_hit);
    end

    // Hazard decode and next-state logic; outputs are combinational.
    always_comb begin
        pc_freeze     = 1'b0;
        ifid_freeze   = 1'b0;
        ifid_flush    = 1'b0;
        idex_freeze   = 1'b0;
        idex_flush    = 1'b0;
        exmem_freeze  = 1'b0;
        mem_abort     = 1'b0;
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        timeout_err_d = timeout_err_q;

        unique case (state_q)
            RUN: begin
                if (mem_req && !mem_ready) begin
                    pc_freeze    = 1'b1;
                    ifid_freeze  = 1'b1;
                    idex_freeze  = 1'b1;
                    exmem_freeze = 1'b1;
                    state_d      = MEM_WAIT;
                    wait_cnt_d   = 16'd1;
                end else if (branch_taken) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (load_use) begin
                    pc_freeze   = 1'b1;
                    ifid_freeze = 1'b1;
                    idex_flush  = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    // Access completes: resolve as RUN without the memory stall.
                    state_d    = RUN;
                    wait_cnt_d = '0;
                    if (branch_taken) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (load_use) begin
                        pc_freeze   = 1'b1;
                        ifid_freeze = 1'b1;
                        idex_flush  = 1'b1;
                    end
                end else if (wait_cnt_q == TMO) begin
                    // Give up: release the pipe and flag the error.
                    mem_abort     = 1'b1;
                    timeout_err_d = 1'b1;
                    state_d       = RUN;
                    wait_cnt_d    = '0;
                end else begin
                    pc_freeze    = 1'b1;
                    ifid_freeze  = 1'b1;
                    idex_freeze  = 1'b1;
                    exmem_freeze = 1'b1;
                    wait_cnt_d   = wait_cnt_q + 16'd1;
                end
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    assign timeout_err = timeout_err_q;

    // State, wait counter and sticky timeout flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RUN;
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

`ifdef PIPE_HAZARD_PERF_CNT_EN
    logic [15:0] stall_q;

    // Saturating count of cycles with the PC held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if (pc_freeze && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed vector bench for pipe_hazard_ctrl (timeout shortened to 8).
// Output vector order: pc, ifid_fz, ifid_fl, idex_fz, idex_fl, exmem_fz, abort, err.
module tb_pipe_hazard_ctrl;

    localparam int AW = 4;

    localparam logic [7:0] E_NONE = 8'b0000_0000;
    localparam logic [7:0] E_LU   = 8'b1100_1000;
    localparam logic [7:0] E_BR   = 8'b0010_1000;
    localparam logic [7:0] E_MEM  = 8'b1101_0100;
    localparam logic [7:0] E_ABT  = 8'b0000_0010;
    localparam logic [7:0] E_ERR  = 8'b0000_0001;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] id_src1 = '0;
    logic [AW-1:0] id_src2 = '0;
    logic          id_two_src = 1'b0;
    logic [AW-1:0] ex_dest = '0;
    logic          ex_mem_read = 1'b0;
    logic          branch_taken = 1'b0;
    logic          mem_req = 1'b0;
    logic          mem_ready = 1'b0;
    logic          pc_freeze, ifid_freeze, ifid_flush;
    logic          idex_freeze, idex_flush, exmem_freeze;
    logic          mem_abort, timeout_err;
`ifdef PIPE_HAZARD_PERF_CNT_EN
    logic [15:0]   stall_cycles;
`endif

    logic [7:0] outs;
    int checks = 0;
    int errors = 0;

    typedef struct {
        string         name;
        logic [AW-1:0] s1;
        logic [AW-1:0] s2;
        logic          two;
        logic [AW-1:0] dst;
        logic          rd;
        logic          br;
        logic          req;
        logic          rdy;
        logic [7:0]    exp;
    } vec_t;

    vec_t vecs[10];

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .REG_AW(AW),
        .WAIT_TIMEOUT(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .id_src1(id_src1),
        .id_src2(id_src2),
        .id_two_src(id_two_src),
        .ex_dest(ex_dest),
        .ex_mem_read(ex_mem_read),
        .branch_taken(branch_taken),
        .mem_req(mem_req),
        .mem_ready(mem_ready),
        .pc_freeze(pc_freeze),
        .ifid_freeze(ifid_freeze),
        .ifid_flush(ifid_flush),
        .idex_freeze(idex_freeze),
        .idex_flush(idex_flush),
        .exmem_freeze(exmem_freeze),
        .mem_abort(mem_abort),
        .timeout_err(timeout_err)
`ifdef PIPE_HAZARD_PERF_CNT_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    assign outs = {pc_freeze, ifid_freeze, ifid_flush, idex_freeze,
                   idex_flush, exmem_freeze, mem_abort, timeout_err};

    task automatic chk(input string name, input logic [7:0] exp);
        checks++;
        if (outs !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, outs, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        id_src1      = v.s1;
        id_src2      = v.s2;
        id_two_src   = v.two;
        ex_dest      = v.dst;
        ex_mem_read  = v.rd;
        branch_taken = v.br;
        mem_req      = v.req;
        mem_ready    = v.rdy;
    endtask

    task automatic idle();
        id_src1      = '0;
        id_src2      = '0;
        id_two_src   = 1'b0;
        ex_dest      = '0;
        ex_mem_read  = 1'b0;
        branch_taken = 1'b0;
        mem_req      = 1'b0;
        mem_ready    = 1'b0;
    endtask

    initial begin
        vecs[0] = '{"idle",       4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE};
        vecs[1] = '{"lu_src1",    4'd3, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, E_LU};
        vecs[2] = '{"lu_x0",      4'd0, 4'd0, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, E_NONE};
        vecs[3] = '{"lu_src2",    4'd1, 4'd5, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, E_LU};
        vecs[4] = '{"src2_unused",4'd1, 4'd5, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, E_NONE};
        vecs[5] = '{"not_load",   4'd3, 4'd0, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE};
        vecs[6] = '{"branch",     4'd2, 4'd4, 1'b1, 4'd7, 1'b0, 1'b1, 1'b0, 1'b0, E_BR};
        vecs[7] = '{"branch_lu",  4'd3, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, E_BR};
        vecs[8] = '{"req_ready",  4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, E_NONE};
        vecs[9] = '{"lu_miss",    4'd2, 4'd6, 1'b1, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0, E_NONE};

        // Reset state
        #2;
        chk("reset", E_NONE);
`ifdef PIPE_HAZARD_PERF_CNT_EN
        checks++;
        if (stall_cycles !== 16'd0) begin
            errors++;
            $display("FAIL stall_rst: got %0d expected 0", stall_cycles);
        end
`endif
        @(negedge clk);
        rst = 1'b0;

        // Combinational decode in RUN
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #2;
            chk(vecs[i].name, vecs[i].exp);
        end

        // Memory wait: 4 cycles not ready, then ready
        @(negedge clk);
        idle();
        mem_req = 1'b1;
        #2;
        chk("mw_run", E_MEM);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            if (i == 2) begin
                branch_taken = 1'b1;
                ex_mem_read  = 1'b1;
                ex_dest      = 4'd3;
                id_src1      = 4'd3;
            end
            #2;
            chk("mw_hold", E_MEM);
        end
        @(negedge clk);
        mem_ready = 1'b1;
        #2;
        chk("mw_ready_br", E_BR);
        @(negedge clk);
        mem_req      = 1'b0;
        mem_ready    = 1'b0;
        branch_taken = 1'b0;
        #2;
        chk("mw_back_run", E_LU);

        // Timeout with ready never arriving
        @(negedge clk);
        idle();
        mem_req = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) @(negedge clk);
            #2;
            chk(i < 8 ? "to_hold" : "to_abort", i < 8 ? E_MEM : E_ABT);
        end
        @(negedge clk);
        mem_req = 1'b0;
        #2;
        chk("to_sticky", E_ERR);
        @(negedge clk);
        ex_mem_read = 1'b1;
        ex_dest     = 4'd4;
        id_src1     = 4'd4;
        #2;
        chk("to_sticky_lu", E_LU | E_ERR);

        // Ready wins over timeout in the same cycle
        @(negedge clk);
        idle();
        mem_req = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 8) mem_ready = 1'b1;
            #2;
            chk(i < 8 ? "pri_hold" : "pri_ready", i < 8 ? (E_MEM | E_ERR) : E_ERR);
        end
        @(negedge clk);
        idle();
        #2;
        chk("pri_after", E_ERR);

        // Reset in the middle of a memory wait
        @(negedge clk);
        mem_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
        end
        #2;
        chk("rw_pre", E_MEM | E_ERR);
        rst     = 1'b1;
        mem_req = 1'b0;
        #1;
        chk("rw_async", E_NONE);
`ifdef PIPE_HAZARD_PERF_CNT_EN
        checks++;
        if (stall_cycles !== 16'd0) begin
            errors++;
            $display("FAIL stall_rw: got %0d expected 0", stall_cycles);
        end
`endif
        @(negedge clk);
        #2;
        chk("rw_hold", E_NONE);
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk("rw_release", E_NONE);
        @(negedge clk);
        #2;
        chk("rw_after", E_NONE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
